dm_sba_ctrl: RTL and testbench
==============================

# dm_sba_ctrl

System Bus Access (SBA) controller for the RISC-V debug module. It sits directly downstream of the DM CSR block and consumes the decoded sbcs/sbaddress/sbdata fields and write/read strobes. It drives a single-outstanding request/grant/response bus master port and returns read data, auto-incremented address and error pulses to the CSR block. The CSR block owns the sticky sbcs bits; this block only produces one-cycle event pulses.

## Interface
- BusWidth, 32, bus data/address width; only 32 is supported.
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- dmactive_i  in  1  DM active; low aborts the block to Idle
- sbaddress_i  in  32  current sbaddress0
- sbaddress_write_valid_i  in  1  pulse: debugger wrote sbaddress0
- sbdata_i  in  32  current sbdata0
- sbdata_write_valid_i  in  1  pulse: debugger wrote sbdata0
- sbdata_read_valid_i  in  1  pulse: debugger read sbdata0
- sbreadonaddr_i, sbreadondata_i, sbautoincrement_i  in  1 each  sbcs control bits
- sbaccess_i  in  3  access size, log2 bytes
- sbaddress_o  in→out  32  next address (sbaddress_i + 2^sbaccess_i)
- sbaddress_update_o  out  1  pulse: CSR block loads sbaddress_o
- sbdata_o  out  32  read data, right-aligned, zero-extended
- sbdata_valid_o  out  1  pulse: CSR block loads sbdata_o
- sbbusy_o  out  1  access in progress
- sbbusyerror_o  out  1  pulse: trigger strobe while busy
- sberror_valid_o  out  1  pulse; sberror_o  out  3  error code
- master_req_o  out  1; master_add_o  out  32; master_we_o  out  1; master_wdata_o  out  32; master_be_o  out  4
- master_gnt_i  in  1; master_r_valid_i  in  1; master_r_rdata_i  in  32; master_r_err_i  in  1

## Operation
- FSM states: Idle, Read, Write, WaitRead, WaitWrite (3-bit encoding 0..4).
- Idle triggers, highest priority first:
  - sbaddress_write_valid_i && sbreadonaddr_i → Read.
  - sbdata_write_valid_i → Write.
  - sbdata_read_valid_i && sbreadondata_i → Read.
- Pre-checks apply at trigger time; a failing trigger stays Idle with no bus request.
  - sbaccess_i > 2: sberror_o=4 (size unsupported).
  - Address misaligned for the size: sberror_o=3.
- Read/Write: master_req_o=1, master_add_o={sbaddress_i[31:2],2'b00}, master_we_o=(state==Write). Hold until master_gnt_i, then go to WaitRead/WaitWrite.
- master_be_o:
  - size 0: 4'b0001<<addr[1:0]
  - size 1: 4'b0011<<{addr[1],1'b0}
  - size 2: 4'hF
  - 0 when not requesting.
- master_wdata_o = sbdata_i << (8*addr[1:0]).
- WaitRead, on master_r_valid_i:
  - sbdata_o = (rdata >> 8*addr[1:0]) masked to the access size.
  - Pulse sbdata_valid_o.
  - If sbautoincrement_i, pulse sbaddress_update_o.
  - Go to Idle.
- WaitWrite, on master_r_valid_i: pulse sbaddress_update_o if sbautoincrement_i; go to Idle.
- master_r_err_i with r_valid: sberror_valid_o=1, sberror_o=2. sbdata_valid_o and sbaddress_update_o are suppressed.
- sbbusy_o = (state != Idle).
- Any trigger strobe while sbbusy_o=1 pulses sbbusyerror_o and is otherwise ignored.
- sbaddress_o = sbaddress_i + (32'd1 << sbaccess_i), modulo 2^32. 32'hFFFFFFFC + 4 wraps to 0.
- dmactive_i=0: state → Idle on the next edge and master_req_o drops. A response arriving later in Idle is ignored, producing no pulses.

## Timing
- Reset: state Idle; all outputs 0 (master_*, sbdata_o, pulses, sbbusy_o, sberror_o). sbaddress_o is combinational from inputs.
- master_req_o, master_we_o, master_be_o and sbbusy_o decode the registered state.
- sbdata_o, sbdata_valid_o, sbaddress_update_o, sberror_* and sbbusyerror_o are registered, asserting one cycle after their cause.
- Minimum read sequence: trigger at cycle T; req at T+1 with gnt at T+1; r_valid at T+2; sbdata_valid_o and sbbusy_o=0 at T+3.
- A response is only accepted in WaitRead/WaitWrite, so r_valid in the same cycle as gnt is not accepted.
- A trigger in the same cycle the FSM returns to Idle (sbbusy_o still 1) is a busy error.
- Request signals are stable while master_req_o=1 and not granted.

## Test plan
- Read-on-address: sbaccess=2, write sbaddress=0x1000, gnt same cycle, rdata=0xDEADBEEF one cycle later → master_add_o=0x1000, be=0xF, sbdata_o=0xDEADBEEF at T+3; with autoincrement, sbaddress_o=0x1004 and sbaddress_update_o pulse.
- Byte write: sbaccess=0, addr=0x2003, sbdata=0xA5 → be=4'b1000, wdata=0xA5000000, we=1; no error.
- Errors:
  - sbaccess=3 → sberror 4, no req.
  - sbaccess=2, addr=0x2 → sberror 3.
  - r_err on read → sberror 2, no sbdata_valid_o.
- Busy: sbdata write issued while in WaitRead → sbbusyerror_o pulse; FSM and bus unaffected.
- Abort: drop dmactive_i while in Read with gnt=0 → req low next cycle, Idle; late r_valid → no pulses.
- Wrap: addr=0xFFFFFFFC, sbaccess=2, autoincrement → sbaddress_o=0x00000000.

Source files
------------

// File: rtl/dm_sba_ctrl.sv
// dm_sba_ctrl: debug-module system bus access controller, single-outstanding bus master with event pulses to the CSR block
module dm_sba_ctrl #(
    parameter int BusWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dmactive_i,
    input  logic [BusWidth-1:0] sbaddress_i,
    input  logic                sbaddress_write_valid_i,
    input  logic [BusWidth-1:0] sbdata_i,
    input  logic                sbdata_write_valid_i,
    input  logic                sbdata_read_valid_i,
    input  logic                sbreadonaddr_i,
    input  logic                sbreadondata_i,
    input  logic                sbautoincrement_i,
    input  logic [2:0]          sbaccess_i,
    output logic [BusWidth-1:0] sbaddress_o,
    output logic                sbaddress_update_o,
    output logic [BusWidth-1:0] sbdata_o,
    output logic                sbdata_valid_o,
    output logic                sbbusy_o,
    output logic                sbbusyerror_o,
    output logic                sberror_valid_o,
    output logic [2:0]          sberror_o,
    output logic                master_req_o,
    output logic [BusWidth-1:0] master_add_o,
    output logic                master_we_o,
    output logic [BusWidth-1:0] master_wdata_o,
    output logic [3:0]          master_be_o,
    input  logic                master_gnt_i,
    input  logic                master_r_valid_i,
    input  logic [BusWidth-1:0] master_r_rdata_i,
    input  logic                master_r_err_i
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        READ       = 3'd1,
        WRITE      = 3'd2,
        WAIT_READ  = 3'd3,
        WAIT_WRITE = 3'd4
    } state_t;
    state_t state, state_next;
    logic rd_on_addr, trig, size_err, misalign, resp, rd_ok;
    logic [1:0] off;
    logic [BusWidth-1:0] rshift, rdata_aligned;
    always_comb begin
        rd_on_addr = sbaddress_write_valid_i && sbreadonaddr_i;
        trig = rd_on_addr || sbdata_write_valid_i || (sbdata_read_valid_i && sbreadondata_i);
        size_err = sbaccess_i > 3'd2;
        misalign = (sbaccess_i == 3'd1 && sbaddress_i[0]) || (sbaccess_i == 3'd2 && sbaddress_i[1:0] != 2'b00);
        resp = master_r_valid_i && (state == WAIT_READ || state == WAIT_WRITE);
        rd_ok = dmactive_i && resp && state == WAIT_READ && !master_r_err_i;
        off = sbaddress_i[1:0];
        rshift = master_r_rdata_i >> {off, 3'b000};
        rdata_aligned = sbaccess_i == 3'd0 ? {24'd0, rshift[7:0]} :
                        sbaccess_i == 3'd1 ? {16'd0, rshift[15:0]} : rshift;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:                  if (trig && !size_err && !misalign)
                                       state_next = rd_on_addr ? READ : sbdata_write_valid_i ? WRITE : READ;
            READ:                  if (master_gnt_i) state_next = WAIT_READ;
            WRITE:                 if (master_gnt_i) state_next = WAIT_WRITE;
            WAIT_READ, WAIT_WRITE: if (master_r_valid_i) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
        if (!dmactive_i) state_next = IDLE;
    end
    always_comb begin
        master_req_o = state == READ || state == WRITE;
        master_we_o = state == WRITE;
        master_add_o = master_req_o ? {sbaddress_i[31:2], 2'b00} : '0;
        master_wdata_o = master_req_o ? sbdata_i << {off, 3'b000} : '0;
        master_be_o = !master_req_o ? 4'h0 :
                      sbaccess_i == 3'd0 ? 4'b0001 << off :
                      sbaccess_i == 3'd1 ? 4'b0011 << {off[1], 1'b0} : 4'hF;
        sbbusy_o = state != IDLE;
        sbaddress_o = sbaddress_i + (32'd1 << sbaccess_i);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sbdata_o <= '0;
            sbdata_valid_o <= 1'b0;
            sbaddress_update_o <= 1'b0;
            sberror_valid_o <= 1'b0;
            sberror_o <= 3'd0;
            sbbusyerror_o <= 1'b0;
        end else begin
            if (rd_ok) sbdata_o <= rdata_aligned;
            sbdata_valid_o <= rd_ok;
            sbaddress_update_o <= dmactive_i && resp && !master_r_err_i && sbautoincrement_i;
            sberror_valid_o <= dmactive_i && ((resp && master_r_err_i) || (state == IDLE && trig && (size_err || misalign)));
            sberror_o <= !dmactive_i ? 3'd0 :
                         resp && master_r_err_i ? 3'd2 :
                         state != IDLE || !trig ? 3'd0 :
                         size_err ? 3'd4 : misalign ? 3'd3 : 3'd0;
            sbbusyerror_o <= dmactive_i && trig && state != IDLE;
        end
    end
endmodule

// File: tb/tb_dm_sba_ctrl.sv
// tb_dm_sba_ctrl: randomized transaction bench for dm_sba_ctrl against an arithmetic reference model
module tb_dm_sba_ctrl;
    logic        clk_i = 0, rst_i = 1, dmactive_i = 0;
    logic [31:0] sbaddress_i = 0, sbdata_i = 0;
    logic        sbaddress_write_valid_i = 0, sbdata_write_valid_i = 0, sbdata_read_valid_i = 0;
    logic        sbreadonaddr_i = 0, sbreadondata_i = 0, sbautoincrement_i = 0;
    logic [2:0]  sbaccess_i = 0;
    logic [31:0] sbaddress_o, sbdata_o;
    logic        sbaddress_update_o, sbdata_valid_o, sbbusy_o, sbbusyerror_o, sberror_valid_o;
    logic [2:0]  sberror_o;
    logic        master_req_o, master_we_o;
    logic [31:0] master_add_o, master_wdata_o;
    logic [3:0]  master_be_o;
    logic        master_gnt_i = 0, master_r_valid_i = 0, master_r_err_i = 0;
    logic [31:0] master_r_rdata_i = 0;
    int vectors = 0, miscompares = 0;

    dm_sba_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .dmactive_i(dmactive_i),
        .sbaddress_i(sbaddress_i), .sbaddress_write_valid_i(sbaddress_write_valid_i),
        .sbdata_i(sbdata_i), .sbdata_write_valid_i(sbdata_write_valid_i),
        .sbdata_read_valid_i(sbdata_read_valid_i), .sbreadonaddr_i(sbreadonaddr_i),
        .sbreadondata_i(sbreadondata_i), .sbautoincrement_i(sbautoincrement_i),
        .sbaccess_i(sbaccess_i), .sbaddress_o(sbaddress_o), .sbaddress_update_o(sbaddress_update_o),
        .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid_o), .sbbusy_o(sbbusy_o),
        .sbbusyerror_o(sbbusyerror_o), .sberror_valid_o(sberror_valid_o), .sberror_o(sberror_o),
        .master_req_o(master_req_o), .master_add_o(master_add_o), .master_we_o(master_we_o),
        .master_wdata_o(master_wdata_o), .master_be_o(master_be_o), .master_gnt_i(master_gnt_i),
        .master_r_valid_i(master_r_valid_i), .master_r_rdata_i(master_r_rdata_i),
        .master_r_err_i(master_r_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // kind: 0 read-on-address, 1 data write, 2 read-on-data
    task automatic do_txn(input int kind, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] data, input bit ai, input int gd, input int rd,
                          input bit err, input bit poke, input logic [31:0] rdata);
        int nbytes = 1 << size;
        int off = int'(addr % 4);
        bit serr = size > 2;
        bit mis = !serr && (addr % nbytes != 0);
        bit is_read = kind != 1;
        logic [31:0] exp_next = addr + nbytes;
        logic [31:0] exp_be = ((1 << nbytes) - 1) << off;
        logic [31:0] exp_wdata = data << (8 * off);
        logic [31:0] exp_rdata = (rdata >> (8 * off)) & (size == 2 ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 1);
        sbaddress_i = addr;
        sbaccess_i = size;
        sbdata_i = data;
        sbautoincrement_i = ai;
        sbreadonaddr_i = kind == 0;
        sbreadondata_i = kind == 2;
        sbaddress_write_valid_i = kind == 0;
        sbdata_write_valid_i = kind == 1;
        sbdata_read_valid_i = kind == 2;
        #1;
        chk("next_addr", sbaddress_o, exp_next);
        chk("idle_busy", {31'd0, sbbusy_o}, 0);
        tick();
        sbaddress_write_valid_i = 0;
        sbdata_write_valid_i = 0;
        sbdata_read_valid_i = 0;
        if (serr || mis) begin
            chk("pre_err_valid", {31'd0, sberror_valid_o}, 1);
            chk("pre_err_code", {29'd0, sberror_o}, serr ? 4 : 3);
            chk("pre_err_req", {31'd0, master_req_o}, 0);
            chk("pre_err_busy", {31'd0, sbbusy_o}, 0);
            return;
        end
        chk("trig_err", {31'd0, sberror_valid_o}, 0);
        for (int i = 0; i <= gd; i++) begin
            chk("req", {31'd0, master_req_o}, 1);
            chk("add", master_add_o, addr & 32'hFFFF_FFFC);
            chk("we", {31'd0, master_we_o}, {31'd0, !is_read});
            chk("be", {28'd0, master_be_o}, exp_be);
            if (!is_read) chk("wdata", master_wdata_o, exp_wdata);
            chk("busy", {31'd0, sbbusy_o}, 1);
            if (i == gd) master_gnt_i = 1;
            tick();
            master_gnt_i = 0;
        end
        chk("req_after_gnt", {31'd0, master_req_o}, 0);
        for (int j = 0; j < rd; j++) begin
            if (j == 0 && poke) sbdata_write_valid_i = 1;
            tick();
            sbdata_write_valid_i = 0;
            if (j == 0 && poke) chk("busy_err", {31'd0, sbbusyerror_o}, 1);
            chk("wait_busy", {31'd0, sbbusy_o}, 1);
            chk("wait_req", {31'd0, master_req_o}, 0);
            chk("wait_dvalid", {31'd0, sbdata_valid_o}, 0);
        end
        master_r_valid_i = 1;
        master_r_err_i = err;
        master_r_rdata_i = rdata;
        tick();
        master_r_valid_i = 0;
        master_r_err_i = 0;
        chk("done_busy", {31'd0, sbbusy_o}, 0);
        chk("dvalid", {31'd0, sbdata_valid_o}, {31'd0, is_read && !err});
        chk("addr_upd", {31'd0, sbaddress_update_o}, {31'd0, ai && !err});
        chk("err_valid", {31'd0, sberror_valid_o}, {31'd0, err});
        if (err) chk("err_code", {29'd0, sberror_o}, 2);
        if (is_read && !err) chk("rdata", sbdata_o, exp_rdata);
        chk("no_busy_err", {31'd0, sbbusyerror_o}, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req", {31'd0, master_req_o}, 0);
        chk("rst_busy", {31'd0, sbbusy_o}, 0);
        chk("rst_sbdata", sbdata_o, 0);
        chk("rst_pulses", {27'd0, sbdata_valid_o, sbaddress_update_o, sberror_valid_o, sbbusyerror_o, master_we_o}, 0);
        chk("rst_bus", master_add_o | master_wdata_o | {28'd0, master_be_o} | {29'd0, sberror_o}, 0);
        rst_i = 0;
        dmactive_i = 1;
        tick();
        do_txn(0, 32'h1000, 2, 32'h0, 1, 0, 0, 0, 0, 32'hDEADBEEF);
        do_txn(1, 32'h2003, 0, 32'hA5, 0, 0, 0, 0, 0, 32'h0);
        do_txn(1, 32'h2000, 3, 32'h1, 0, 0, 0, 0, 0, 32'h0);
        do_txn(0, 32'h2, 2, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        do_txn(0, 32'h40, 2, 32'h0, 1, 1, 1, 1, 0, 32'h12345678);
        do_txn(2, 32'h82, 1, 32'h0, 0, 0, 2, 0, 1, 32'hCAFEF00D);
        do_txn(0, 32'hFFFF_FFFC, 2, 32'h0, 1, 0, 0, 0, 0, 32'h55AA55AA);
        // abort while requesting, then a late response must be ignored
        sbaddress_i = 32'h300;
        sbaccess_i = 2;
        sbreadonaddr_i = 1;
        sbautoincrement_i = 1;
        sbaddress_write_valid_i = 1;
        tick();
        sbaddress_write_valid_i = 0;
        chk("abort_req_before", {31'd0, master_req_o}, 1);
        dmactive_i = 0;
        tick();
        chk("abort_req", {31'd0, master_req_o}, 0);
        chk("abort_busy", {31'd0, sbbusy_o}, 0);
        dmactive_i = 1;
        master_r_valid_i = 1;
        master_r_rdata_i = 32'h77;
        tick();
        master_r_valid_i = 0;
        chk("late_rsp", {29'd0, sbdata_valid_o, sbaddress_update_o, sberror_valid_o}, 0);
        for (int n = 0; n < 200; n++) begin
            logic [2:0] size = 3'($urandom_range(0, 4));
            logic [31:0] addr = $urandom;
            bit poke = $urandom_range(0, 3) == 0;
            int rd = $urandom_range(0, 2);
            if ($urandom_range(0, 3) != 0 && size <= 2) addr = addr & ~((32'd1 << size) - 1);
            if (poke && rd == 0) rd = 1;
            do_txn($urandom_range(0, 2), addr, size, $urandom, 1'($urandom), $urandom_range(0, 2),
                   rd, $urandom_range(0, 4) == 0, poke, $urandom);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
